// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: digit codes,
// scan geometry, controller state encoding and BCD helper functions.
package calc_pkg;

  // Digit code understood by the seven-segment decoder as a minus sign.
  localparam logic [3:0] DIG_MINUS = 4'd10;

  // Number of multiplexed display positions (ones, tens, hundreds, sign).
  localparam int NUM_DIGITS = 4;

  // One shift-add-3 iteration per magnitude bit.
  localparam logic [3:0] BCD_ITERS = 4'd8;

  // Anode pattern driven for a position that shows nothing.
  localparam logic [NUM_DIGITS-1:0] AN_BLANK = '1;

  // Conversion controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Double-dabble correction: every BCD nibble that is 5 or more gets 3
  // added so that the following left shift carries correctly into the
  // next decade.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low one-hot anode enable for a scan position.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    return ~onehot;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// start_i loads the magnitude and clears the BCD accumulator on the same
// edge; the following eight edges each perform one adjust-and-shift.
// done_o is high during the cycle whose closing edge performs the final
// iteration, so bcd_o holds the finished result from the next cycle on.
import calc_pkg::*;

module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  mag_i,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  // {bcd[11:0], remaining magnitude bits[7:0]} shifted as one word.
  logic [19:0] shift_q;
  logic [19:0] shift_d;
  logic [3:0]  cnt_q;
  logic [11:0] adj;

  // One double-dabble step on the current working word.
  always_comb begin
    adj     = bcd_adjust(shift_q[19:8]);
    shift_d = {adj, shift_q[7:0]} << 1;
  end

  // Load on start, then iterate while the iteration counter is nonzero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      shift_q <= {12'd0, mag_i};
      cnt_q   <= BCD_ITERS;
    end else if (cnt_q != 4'd0) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_q - 4'd1;
    end
  end

  assign done_o = (cnt_q == 4'd1);
  assign bcd_o  = shift_q[19:8];

endmodule

// File: rtl/display_scanner.sv
// Front end of the seven-segment display: captures a signed result,
// converts it to sign plus three BCD digits, commits it atomically to the
// display registers, and time-multiplexes four positions onto one digit
// code with active-low anode enables. Leading zeros and a positive sign
// are blanked; blank positions drive all anodes off and code 0.
import calc_pkg::*;

module display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value_i,
  input  logic             load_i,
  output logic             busy_o,
  output logic [3:0]       digit_o,
  output logic [3:0]       an_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Controller state and the sign captured with the pending value.
  state_e state_q;
  logic   busy_q;
  logic   neg_q;

  // Currently displayed value.
  logic        disp_neg_q;
  logic [11:0] disp_bcd_q;
  logic        disp_neg_d;
  logic [11:0] disp_bcd_d;

  // Scan timing and registered outputs.
  logic [CNT_W-1:0] ref_cnt_q;
  logic [CNT_W-1:0] ref_cnt_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [3:0]       an_q;
  logic [3:0]       an_d;
  logic [3:0]       digit_q;
  logic [3:0]       digit_d;

  // Converter interface.
  logic        start;
  logic [7:0]  mag;
  logic        conv_done;
  logic [11:0] conv_bcd;
  logic        commit;

  // A load is only accepted while idle; -128 maps to magnitude 128.
  always_comb begin
    start = (state_q == IDLE) && load_i;
    mag   = value_i[WIDTH-1] ? (~value_i + 8'd1) : value_i;
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .mag_i   (mag),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Capture, wait for the converter, then commit sign and digits together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      neg_q      <= 1'b0;
      disp_neg_q <= 1'b0;
      disp_bcd_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            neg_q   <= value_i[WIDTH-1];
            state_q <= CONVERT;
            busy_q  <= 1'b1;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          disp_neg_q <= neg_q;
          disp_bcd_q <= conv_bcd;
          state_q    <= IDLE;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next scan position and the display contents it will show, so the
  // registered anode and digit always match the index and committed value.
  always_comb begin
    ref_cnt_d = ref_cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (ref_cnt_q == CNT_LAST) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
    commit     = (state_q == COMMIT);
    disp_neg_d = commit ? neg_q    : disp_neg_q;
    disp_bcd_d = commit ? conv_bcd : disp_bcd_q;
  end

  // Select the digit code and anode for the upcoming position, blanking
  // leading zeros and a positive sign.
  always_comb begin
    an_d    = AN_BLANK;
    digit_d = 4'd0;
    case (idx_d)
      2'd0: begin
        an_d    = anode_for(2'd0);
        digit_d = disp_bcd_d[3:0];
      end
      2'd1: begin
        if (disp_bcd_d[11:4] != 8'd0) begin
          an_d    = anode_for(2'd1);
          digit_d = disp_bcd_d[7:4];
        end
      end
      2'd2: begin
        if (disp_bcd_d[11:8] != 4'd0) begin
          an_d    = anode_for(2'd2);
          digit_d = disp_bcd_d[11:8];
        end
      end
      default: begin
        if (disp_neg_d) begin
          an_d    = anode_for(2'd3);
          digit_d = DIG_MINUS;
        end
      end
    endcase
  end

  // Free-running refresh counter, scan index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q <= '0;
      idx_q     <= 2'd0;
      an_q      <= anode_for(2'd0);
      digit_q   <= 4'd0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
    end
  end

  assign busy_o  = busy_q;
  assign an_o    = an_q;
  assign digit_o = digit_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with REFRESH_DIV = 4. A scan-position
// reference tracks which of the four slots should be on the outputs so
// every sample can be filed under its position.
module tb_display_scanner;

  logic       clk;
  logic       rst_n;
  logic       load_i;
  logic [7:0] value_i;
  logic       busy_o;
  logic [3:0] digit_o;
  logic [3:0] an_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference scan position: held 4 cycles, advancing 0,1,2,3,0.
  logic [1:0] m_cnt;
  logic [1:0] m_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 2'd0;
      m_idx <= 2'd0;
    end else if (m_cnt == 2'd3) begin
      m_cnt <= 2'd0;
      m_idx <= m_idx + 2'd1;
    end else begin
      m_cnt <= m_cnt + 2'd1;
    end
  end

  display_scanner #(.REFRESH_DIV(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_i (value_i),
    .load_i  (load_i),
    .busy_o  (busy_o),
    .digit_o (digit_o),
    .an_o    (an_o)
  );

  // Sample 16 cycles and keep what each scan position showed.
  task automatic capture(output logic [15:0] dig, output logic [15:0] an);
    dig = 'x;
    an  = 'x;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      dig[int'(m_idx)*4 +: 4] = digit_o;
      an[int'(m_idx)*4 +: 4]  = an_o;
    end
  endtask

  // Pulse load for one edge and count the cycles busy_o stays high.
  task automatic do_load(input logic [7:0] v, output int busy_cycles);
    @(negedge clk);
    value_i = v;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy_o) break;
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [15:0] dig, an, ed, ea;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++;
    if (an_o !== 4'b1110) begin n_bad++; $display("FAIL reset_an: got %b want 1110", an_o); end
    n_cmp++;
    if (digit_o !== 4'd0) begin n_bad++; $display("FAIL reset_digit: got %0d want 0", digit_o); end
    rst_n = 1'b1;
    capture(dig, an);
    ed = {4'd0, 4'd0, 4'd0, 4'd0};
    ea = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL reset_disp pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
  endtask

  task automatic test_positive_123();
    logic [15:0] dig, an, ed, ea;
    int bc;
    do_load(8'd123, bc);
    n_cmp++;
    if (bc !== 9) begin n_bad++; $display("FAIL busy_len_123: got %0d want 9", bc); end
    capture(dig, an);
    ed = {4'd0, 4'd1, 4'd2, 4'd3};
    ea = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_123 pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
  endtask

  task automatic test_negative();
    logic [15:0] dig, an, ed, ea;
    int bc;
    do_load(8'h80, bc);
    n_cmp++;
    if (bc !== 9) begin n_bad++; $display("FAIL busy_len_m128: got %0d want 9", bc); end
    capture(dig, an);
    ed = {4'd10, 4'd1, 4'd2, 4'd8};
    ea = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_m128 pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
    do_load(8'hFB, bc);
    capture(dig, an);
    ed = {4'd10, 4'd0, 4'd0, 4'd5};
    ea = {4'b0111, 4'b1111, 4'b1111, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_m5 pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
  endtask

  task automatic test_ignore_busy_load();
    logic [15:0] dig, an, ed, ea;
    int bc;
    @(negedge clk);
    value_i = 8'd7;
    load_i  = 1'b1;
    @(negedge clk);
    load_i  = 1'b0;
    value_i = 8'd99;
    bc = 0;
    for (int c = 0; c < 20; c++) begin
      if (!busy_o) break;
      bc++;
      load_i = (bc == 3);
      @(negedge clk);
    end
    load_i = 1'b0;
    n_cmp++;
    if (bc !== 9) begin n_bad++; $display("FAIL busy_len_ignore: got %0d want 9", bc); end
    capture(dig, an);
    ed = {4'd0, 4'd0, 4'd0, 4'd7};
    ea = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_ignore pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
  endtask

  task automatic test_reset_mid_convert();
    logic [15:0] dig, an, ed, ea;
    @(negedge clk);
    value_i = 8'd45;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b1) begin n_bad++; $display("FAIL midconv_busy: got %b want 1", busy_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    n_cmp++;
    if (an_o !== 4'b1110 || digit_o !== 4'd0) begin
      n_bad++;
      $display("FAIL abort_out: got an %b digit %0d want an 1110 digit 0", an_o, digit_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    capture(dig, an);
    ed = {4'd0, 4'd0, 4'd0, 4'd0};
    ea = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_abort pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [15:0] dig, an, ed, ea;
    int bc;
    do_load(8'd100, bc);
    capture(dig, an);
    ed = {4'd0, 4'd1, 4'd0, 4'd0};
    ea = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_100 pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
    do_load(8'd9, bc);
    capture(dig, an);
    ed = {4'd0, 4'd0, 4'd0, 4'd9};
    ea = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_9 pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dig, an, ed, ea;
    int bc1, bc2;
    do_load(8'd123, bc1);
    do_load(8'd45, bc2);
    n_cmp++;
    if (bc1 !== 9 || bc2 !== 9) begin
      n_bad++;
      $display("FAIL b2b_busy: got %0d and %0d want 9 and 9", bc1, bc2);
    end
    capture(dig, an);
    ed = {4'd0, 4'd0, 4'd4, 4'd5};
    ea = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (dig[p*4 +: 4] !== ed[p*4 +: 4] || an[p*4 +: 4] !== ea[p*4 +: 4]) begin
        n_bad++;
        $display("FAIL disp_b2b pos%0d: got digit %0d an %b want digit %0d an %b",
                 p, dig[p*4 +: 4], an[p*4 +: 4], ed[p*4 +: 4], ea[p*4 +: 4]);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    load_i  = 1'b0;
    value_i = 8'd0;
    test_reset();
    test_positive_123();
    test_negative();
    test_ignore_busy_load();
    test_reset_mid_convert();
    test_leading_zeros();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Upstream feeder for the seven-segment decoder.
- Accepts a signed 8-bit result from the calculator datapath with a load strobe. Converts it sequentially to sign plus 3 BCD digits using shift-add-3 (one shift per cycle).
- Time-multiplexes 4 digit positions onto one 4-bit digit code plus active-low anode enables.
- Digit code convention: 0-9 = numerals, 10 = minus sign, matching the decoder's input encoding.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit position is held before advancing; must be >= 1; benches use 4.
- WIDTH, 8, input value width; fixed at 8, since the 3-digit BCD range assumes it.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value_i  input  8  signed two's-complement value to display.
- load_i  input  1  capture strobe; sampled only when busy_o is low.
- busy_o  output  1  high while a conversion is in progress.
- digit_o  output  4  digit code for the currently selected position, fed to the decoder.
- an_o  output  4  active-low one-hot anode enables; bit 0 = rightmost (ones) position.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; busy_o = 0.
  - Display registers hold value 0: sign off, digits 0,0,0.
  - Scan index = 0; refresh counter = 0; an_o = 4'b1110; digit_o = 0.
- FSM states IDLE, CONVERT, COMMIT. busy_o = (state != IDLE), registered.
- IDLE:
  - load_i high at edge N captures value_i.
  - Captures neg = value_i[7] and mag = neg ? -value_i : value_i as an 8-bit unsigned value (-128 gives 128).
  - Clears the 12-bit BCD accumulator, loads the 4-bit iteration count, and moves to CONVERT.
- CONVERT:
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by 1.
  - Exactly 8 cycles (edges N+1..N+8), then go to COMMIT.
- COMMIT:
  - At edge N+9, display registers take {neg, hundreds, tens, ones} atomically; state returns to IDLE.
  - busy_o is high after edges N..N+8 and low after edge N+9.
  - Total latency: load edge to new display = 9 cycles.
- load_i while busy_o is high is ignored; no queueing. The display keeps showing the previous value until COMMIT.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the scan index advances 0,1,2,3,0.
  - The scan runs continuously and is independent of FSM state.
- Position mapping:
  - 0 = ones, always shown.
  - 1 = tens, blanked if hundreds == 0 and tens == 0.
  - 2 = hundreds, blanked if 0.
  - 3 = sign: code 10 when neg, blanked otherwise.
- Blank position: an_o = 4'b1111 for that slot and digit_o = 0. The decoder never receives an undefined code (11-15 are never driven).
- an_o and digit_o are registered, and they change together on the same edge.
- Reset mid-conversion: aborts and returns to the reset display (0). No partial result is ever committed.
- Value 0: only position 0 is lit, showing 0. Negative zero cannot occur.

Decomposition:
- Shared package (calc_pkg):
  - DIG_MINUS = 4'd10.
  - NUM_DIGITS = 4.
  - FSM state typedef/localparams (IDLE, CONVERT, COMMIT).
- Sub-module bin2bcd_seq:
  - Holds the sequential shift-add-3 core and its iteration counter.
  - Interface: start, 8-bit magnitude in, done pulse, 12-bit BCD out.
  - The top level handles sign, blanking, FSM commit and scanning.
- The decoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset, REFRESH_DIV=4 -> an_o cycles 1110 every 4 cycles, then 1111 for positions 1-3; digit_o = 0; busy_o = 0.
- Load 8'd123 -> busy_o high for 9 cycles; after commit, positions 0..3 give digit_o 3,2,1 with an_o 1110,1101,1011, and position 3 blank (1111).
- Load 8'h80 (-128) -> positions show 8,2,1 and sign code 10 with an_o 0111; load 8'hFB (-5) -> 5, blank, blank, 10.
- Load 8'd7, then pulse load_i with 8'd99 during busy -> second load ignored; display shows 7 only.
- Load 8'd45, then assert rst_n low at cycle 4 of CONVERT -> display 0, busy_o 0 immediately; 45 never appears.
- Load 8'd100 -> tens position lit with 0 (1,0,0); load 8'd9 -> tens and hundreds blank.
